// File: rtl/diag_scalar_update_if.sv
// Row-stream bundle for the diagonal update stage: input row channel with
// its per-matrix scalar controls, and the output row channel with status.
interface diag_scalar_update_if #(
    parameter int N     = 4,
    parameter int nBits = 32,
    parameter int RW    = 2
);
    logic [nBits*N-1:0] a_data;
    logic               a_valid;
    logic               a_ready;
    logic               a_first;
    logic               mode;
    logic [nBits-1:0]   lambda;
    logic [nBits*N-1:0] b_data;
    logic               b_valid;
    logic               b_ready;
    logic [RW-1:0]      b_row;
    logic               b_last;
    logic               ovf;

    modport master (
        output a_data, a_valid, a_first, mode, lambda, b_ready,
        input  a_ready, b_data, b_valid, b_row, b_last, ovf
    );

    modport slave (
        input  a_data, a_valid, a_first, mode, lambda, b_ready,
        output a_ready, b_data, b_valid, b_row, b_last, ovf
    );
endinterface

// File: rtl/diag_scalar_update.sv
// Streaming B = A +/- lambda*I on packed matrix rows. One output register,
// one row per cycle, row index tracked internally and resynchronised by
// a_first. lambda/mode are taken from the row-0 transfer and held for the
// rest of the matrix.
module diag_scalar_update #(
    parameter int M     = 4,
    parameter int N     = 4,
    parameter int nBits = 32,
    parameter int FRAC  = 15,
    parameter int SAT   = 1
) (
    input  logic clk,
    input  logic rst_n,
    diag_scalar_update_if.slave bus
);
    localparam int RW = (M > 1) ? $clog2(M) : 1;
    localparam logic [RW-1:0]    LAST = RW'(M - 1);
    localparam logic [nBits-1:0] MAXV = {1'b0, {(nBits-1){1'b1}}};
    localparam logic [nBits-1:0] MINV = {1'b1, {(nBits-1){1'b0}}};

    // FRAC only documents the Q format; lambda arrives pre-scaled.
    if (FRAC >= nBits) begin : g_bad_frac
        $error("FRAC must be smaller than nBits");
    end

    logic [RW-1:0]      cnt;
    logic [nBits-1:0]   lam_q;
    logic               mode_q;

    logic               accept;
    logic               emit;
    logic [RW-1:0]      r;
    logic               first;
    logic [nBits-1:0]   lam_eff;
    logic               mode_eff;
    logic [nBits*N-1:0] row_out;
    logic               row_ovf;
    logic [nBits-1:0]   a_j;
    logic [nBits:0]     d;

    assign bus.a_ready = !bus.b_valid || bus.b_ready;
    assign accept      = bus.a_valid && bus.a_ready;
    assign emit        = bus.b_valid && bus.b_ready;

    // Row index, effective scalar, and the diagonal add/subtract with range check.
    always_comb begin
        r        = bus.a_first ? '0 : cnt;
        first    = (r == '0);
        lam_eff  = first ? bus.lambda : lam_q;
        mode_eff = first ? bus.mode : mode_q;
        row_out  = bus.a_data;
        row_ovf  = 1'b0;
        a_j      = '0;
        d        = '0;
        for (int j = 0; j < N; j++) begin
            if (int'(r) == j) begin
                a_j = bus.a_data[j*nBits +: nBits];
                if (mode_eff)
                    d = {a_j[nBits-1], a_j} + {lam_eff[nBits-1], lam_eff};
                else
                    d = {a_j[nBits-1], a_j} - {lam_eff[nBits-1], lam_eff};
                if (d[nBits] != d[nBits-1]) begin
                    row_ovf = 1'b1;
                    if (SAT != 0)
                        row_out[j*nBits +: nBits] = d[nBits] ? MINV : MAXV;
                    else
                        row_out[j*nBits +: nBits] = d[nBits-1:0];
                end else begin
                    row_out[j*nBits +: nBits] = d[nBits-1:0];
                end
            end
        end
    end

    // Output register, row counter, held scalar and sticky overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.b_data  <= '0;
            bus.b_valid <= 1'b0;
            bus.b_row   <= '0;
            bus.b_last  <= 1'b0;
            bus.ovf     <= 1'b0;
            cnt         <= '0;
            lam_q       <= '0;
            mode_q      <= 1'b0;
        end else if (accept) begin
            bus.b_valid <= 1'b1;
            bus.b_data  <= row_out;
            bus.b_row   <= r;
            bus.b_last  <= (r == LAST);
            cnt         <= (r == LAST) ? '0 : r + RW'(1);
            if (first) begin
                lam_q   <= bus.lambda;
                mode_q  <= bus.mode;
                bus.ovf <= row_ovf;
            end else begin
                bus.ovf <= bus.ovf | row_ovf;
            end
        end else if (emit) begin
            bus.b_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_diag_scalar_update.sv
// Directed bench: three instances (M=4 saturating, M=4 wrapping, M=6
// saturating) share one input stream; each scenario checks the instance
// it targets against hand-computed rows.
module tb_diag_scalar_update;
    logic         clk = 1'b0;
    logic         rst_n;
    logic [127:0] a_data;
    logic         a_valid, a_first, mode, b_ready;
    logic [31:0]  lambda;
    int           total = 0;
    int           bad = 0;

    always #5 clk = ~clk;

    diag_scalar_update_if #(.N(4), .nBits(32), .RW(2)) if4s ();
    diag_scalar_update_if #(.N(4), .nBits(32), .RW(2)) if4w ();
    diag_scalar_update_if #(.N(4), .nBits(32), .RW(3)) if6 ();

    assign if4s.a_data = a_data;  assign if4w.a_data = a_data;  assign if6.a_data = a_data;
    assign if4s.a_valid = a_valid; assign if4w.a_valid = a_valid; assign if6.a_valid = a_valid;
    assign if4s.a_first = a_first; assign if4w.a_first = a_first; assign if6.a_first = a_first;
    assign if4s.mode = mode;      assign if4w.mode = mode;      assign if6.mode = mode;
    assign if4s.lambda = lambda;  assign if4w.lambda = lambda;  assign if6.lambda = lambda;
    assign if4s.b_ready = b_ready; assign if4w.b_ready = b_ready; assign if6.b_ready = b_ready;

    diag_scalar_update #(.M(4), .N(4), .nBits(32), .FRAC(15), .SAT(1))
        u4s (.clk(clk), .rst_n(rst_n), .bus(if4s));
    diag_scalar_update #(.M(4), .N(4), .nBits(32), .FRAC(15), .SAT(0))
        u4w (.clk(clk), .rst_n(rst_n), .bus(if4w));
    diag_scalar_update #(.M(6), .N(4), .nBits(32), .FRAC(15), .SAT(1))
        u6 (.clk(clk), .rst_n(rst_n), .bus(if6));

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic f, input logic [127:0] d,
                         input logic md, input logic [31:0] lam);
        a_valid = v;
        a_first = f;
        a_data  = d;
        mode    = md;
        lambda  = lam;
    endtask

    // All four elements = base, except element dpos (if 0..3) = dval.
    function automatic logic [127:0] rowv(input logic [31:0] base, input int dpos,
                                          input logic [31:0] dval);
        logic [127:0] v;
        v = {4{base}};
        if (dpos >= 0 && dpos < 4) v[dpos*32 +: 32] = dval;
        return v;
    endfunction

    initial begin
        rst_n = 1'b0;
        b_ready = 1'b1;
        drive(1'b0, 1'b0, '0, 1'b0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_bvalid", if4s.b_valid, 1'b0);
        chk("rst_bdata", if4s.b_data, '0);
        chk("rst_brow", if4s.b_row, '0);
        chk("rst_blast", if4s.b_last, 1'b0);
        chk("rst_ovf", if4s.ovf, 1'b0);
        chk("rst_aready", if4s.a_ready, 1'b1);
        rst_n = 1'b1;
        tick();

        // Basic subtract of 1.0 from 2.0 on each diagonal, back to back.
        for (int r = 0; r < 4; r++) begin
            drive(1'b1, r == 0, {4{32'h0001_0000}}, 1'b0, 32'h0000_8000);
            chk("t1_aready", if4s.a_ready, 1'b1);
            tick();
            chk("t1_bvalid", if4s.b_valid, 1'b1);
            chk("t1_bdata", if4s.b_data, rowv(32'h0001_0000, r, 32'h0000_8000));
            chk("t1_brow", if4s.b_row, r[1:0]);
            chk("t1_blast", if4s.b_last, r == 3);
            chk("t1_ovf", if4s.ovf, 1'b0);
        end
        a_valid = 1'b0;
        tick();
        chk("t1_idle", if4s.b_valid, 1'b0);

        // Positive overflow: saturate vs wrap, sticky, then cleared by next matrix.
        drive(1'b1, 1'b1, {4{32'h0000_0001}}, 1'b1, 32'h7FFF_FFFF);
        tick();
        chk("t2_sat_data", if4s.b_data, rowv(32'h1, 0, 32'h7FFF_FFFF));
        chk("t2_sat_ovf", if4s.ovf, 1'b1);
        chk("t2_wrap_data", if4w.b_data, rowv(32'h1, 0, 32'h8000_0000));
        chk("t2_wrap_ovf", if4w.ovf, 1'b1);
        drive(1'b1, 1'b0, '0, 1'b0, 32'h0);
        tick();
        chk("t2_row1_data", if4s.b_data, rowv(32'h0, 1, 32'h7FFF_FFFF));
        chk("t2_sticky_sat", if4s.ovf, 1'b1);
        chk("t2_sticky_wrap", if4w.ovf, 1'b1);
        drive(1'b1, 1'b1, {4{32'h0001_0000}}, 1'b0, 32'h0000_8000);
        tick();
        chk("t2_clr_sat", if4s.ovf, 1'b0);
        chk("t2_clr_wrap", if4w.ovf, 1'b0);
        chk("t2_clr_data", if4s.b_data, rowv(32'h0001_0000, 0, 32'h0000_8000));
        a_valid = 1'b0;
        tick();

        // Backpressure: output held, input stalled, then drained in order.
        drive(1'b1, 1'b1, {4{32'h0001_0000}}, 1'b0, 32'h0000_8000);
        tick();
        chk("t3_row0", if4s.b_data, rowv(32'h0001_0000, 0, 32'h0000_8000));
        b_ready = 1'b0;
        drive(1'b1, 1'b0, {4{32'h0001_0100}}, 1'b0, 32'h0);
        #1;
        chk("t3_stall_ardy", if4s.a_ready, 1'b0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("t3_hold_ardy", if4s.a_ready, 1'b0);
            chk("t3_hold_valid", if4s.b_valid, 1'b1);
            chk("t3_hold_data", if4s.b_data, rowv(32'h0001_0000, 0, 32'h0000_8000));
            chk("t3_hold_row", if4s.b_row, 2'd0);
        end
        b_ready = 1'b1;
        #1;
        chk("t3_release_ardy", if4s.a_ready, 1'b1);
        tick();
        chk("t3_row1", if4s.b_data, rowv(32'h0001_0100, 1, 32'h0000_8100));
        chk("t3_row1_idx", if4s.b_row, 2'd1);
        drive(1'b1, 1'b0, {4{32'h0001_0200}}, 1'b0, 32'h0);
        tick();
        chk("t3_row2", if4s.b_data, rowv(32'h0001_0200, 2, 32'h0000_8200));
        chk("t3_row2_idx", if4s.b_row, 2'd2);
        drive(1'b1, 1'b0, {4{32'h0001_0300}}, 1'b0, 32'h0);
        tick();
        chk("t3_row3", if4s.b_data, rowv(32'h0001_0300, 3, 32'h0000_8300));
        chk("t3_row3_last", if4s.b_last, 1'b1);
        a_valid = 1'b0;
        tick();

        // Scalar latch: later rows present a different lambda and mode.
        drive(1'b1, 1'b1, {4{32'h0002_0000}}, 1'b0, 32'h0000_8000);
        tick();
        chk("t4_row0", if4s.b_data, rowv(32'h0002_0000, 0, 32'h0001_8000));
        for (int r = 1; r < 4; r++) begin
            drive(1'b1, 1'b0, {4{32'h0002_0000}}, 1'b1, 32'h0001_0000);
            tick();
            chk("t4_rowN", if4s.b_data, rowv(32'h0002_0000, r, 32'h0001_8000));
        end
        a_valid = 1'b0;
        tick();

        // Resync with a_first mid-matrix, then async reset mid-matrix.
        for (int r = 0; r < 2; r++) begin
            drive(1'b1, r == 0, {4{32'h0001_0000}}, 1'b0, 32'h0000_8000);
            tick();
        end
        chk("t5_pre_row", if4s.b_row, 2'd1);
        drive(1'b1, 1'b1, {4{32'h0001_0000}}, 1'b0, 32'h0000_8000);
        tick();
        chk("t5_resync_row", if4s.b_row, 2'd0);
        chk("t5_resync_data", if4s.b_data, rowv(32'h0001_0000, 0, 32'h0000_8000));
        drive(1'b1, 1'b0, {4{32'h0001_0000}}, 1'b0, 32'h0000_8000);
        tick();
        chk("t5_after_row", if4s.b_row, 2'd1);
        a_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_rst_bvalid", if4s.b_valid, 1'b0);
        chk("t5_rst_brow", if4s.b_row, 2'd0);
        rst_n = 1'b1;
        drive(1'b1, 1'b0, {4{32'h0001_0000}}, 1'b0, 32'h0000_8000);
        tick();
        chk("t5_post_rst_row", if4s.b_row, 2'd0);
        chk("t5_post_rst_data", if4s.b_data, rowv(32'h0001_0000, 0, 32'h0000_8000));
        a_valid = 1'b0;
        tick();

        // M=6, N=4: rows 4 and 5 pass through, last on row 5, wrap to 0.
        for (int r = 0; r < 6; r++) begin
            drive(1'b1, r == 0, {4{32'h0001_0000}}, 1'b0, 32'h0000_8000);
            tick();
            chk("t6_data", if6.b_data, rowv(32'h0001_0000, (r < 4) ? r : -1, 32'h0000_8000));
            chk("t6_row", if6.b_row, r[2:0]);
            chk("t6_last", if6.b_last, r == 5);
        end
        drive(1'b1, 1'b0, {4{32'h0001_0000}}, 1'b0, 32'h0000_8000);
        tick();
        chk("t6_wrap_row", if6.b_row, 3'd0);
        chk("t6_wrap_data", if6.b_data, rowv(32'h0001_0000, 0, 32'h0000_8000));
        a_valid = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
